// File: rtl/counter_chain2.sv
// -----------------------------------------------------------------------------
// counter_chain2
//
// A two-level cascaded loop counter for the compute unit control path. The
// inner counter (count0) advances by stride0 on every enabled step. When the
// inner counter reaches or passes max0, it wraps to zero. On that same step
// the outer counter (count1) advances by stride1. The outer counter wraps
// against max1 in the same way.
//
//   io_wrap0 : combinational, the inner counter wraps on this enabled step.
//   io_done  : combinational, both counters wrap on this step, which is the
//              last iteration of the nest.
//
// The bounds and strides are only ever taken from the config registers. Those
// registers are written by io_config_load, never used straight from the
// input pins.
//
// Optional build macro: COUNTER_CHAIN_STOP_EN
//   Defined   : a sticky io_finished flag sets on the io_done cycle. While the
//               flag is set, io_control_enable is ignored. Reset or
//               io_config_load clears the flag.
//   Undefined : there is no io_finished port. After done, the chain restarts
//               from 0/0 on continued enable.
// -----------------------------------------------------------------------------
module counter_chain2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         io_config_load,
    input  logic [W-1:0] io_config_max0,
    input  logic [W-1:0] io_config_stride0,
    input  logic [W-1:0] io_config_max1,
    input  logic [W-1:0] io_config_stride1,
    input  logic         io_control_enable,
    output logic [W-1:0] io_count0,
    output logic [W-1:0] io_count1,
    output logic         io_wrap0,
    output logic         io_done
`ifdef COUNTER_CHAIN_STOP_EN
    ,
    output logic         io_finished
`endif
);

    // Latched configuration.
    logic [W-1:0] max0_q;
    logic [W-1:0] stride0_q;
    logic [W-1:0] max1_q;
    logic [W-1:0] stride1_q;

    // Loop state.
    logic [W-1:0] count0_q;
    logic [W-1:0] count1_q;

    // Step datapath. The sums are one bit wider than the counts, so a sum
    // such as 15+1 is compared as 16 and does not fold back to 0.
    logic [W:0]   sum0;
    logic [W:0]   sum1;
    logic         step_en;
    logic         run_ok;
    logic         wrap0;
    logic         wrap1;

`ifdef COUNTER_CHAIN_STOP_EN
    logic         finished_q;

    // A finished chain refuses further steps until it is reloaded or reset.
    assign run_ok = ~finished_q;
`else
    assign run_ok = 1'b1;
`endif

    // Step qualification, the two sums, and the two wrap decisions.
    always_comb begin
        // NOTE: every signal written here gets a default value first. Without
        // that, a path that skips an assignment would infer a latch.
        step_en = 1'b0;
        sum0    = '0;
        sum1    = '0;
        wrap0   = 1'b0;
        wrap1   = 1'b0;

        // Reset and load both win over enable. Neither one may produce a
        // step or a wrap pulse.
        step_en = io_control_enable & ~reset & ~io_config_load & run_ok;

        sum0  = {1'b0, count0_q} + {1'b0, stride0_q};
        sum1  = {1'b0, count1_q} + {1'b0, stride1_q};

        wrap0 = step_en & (sum0 >= {1'b0, max0_q});
        wrap1 = wrap0 & (sum1 >= {1'b0, max1_q});
    end

    // Config registers: cleared by reset, captured on load.
    always_ff @(posedge clk) begin
        // NOTE: the config registers are reset because the block defines a
        // zero config state. A register file or RAM would normally be left
        // without a reset.
        if (reset) begin
            max0_q    <= '0;
            stride0_q <= '0;
            max1_q    <= '0;
            stride1_q <= '0;
        end else if (io_config_load) begin
            max0_q    <= io_config_max0;
            stride0_q <= io_config_stride0;
            max1_q    <= io_config_max1;
            stride1_q <= io_config_stride1;
        end
    end

    // Inner counter: wraps to zero or advances by stride0 on each step.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // register in the design samples its inputs from before the edge.
        if (reset || io_config_load) begin
            count0_q <= '0;
        end else if (step_en) begin
            count0_q <= wrap0 ? '0 : sum0[W-1:0];
        end
    end

    // Outer counter: advances only on an inner wrap.
    always_ff @(posedge clk) begin
        if (reset || io_config_load) begin
            count1_q <= '0;
        end else if (wrap0) begin
            count1_q <= wrap1 ? '0 : sum1[W-1:0];
        end
    end

`ifdef COUNTER_CHAIN_STOP_EN
    // Sticky finished flag: set on done, cleared by reset or reload.
    always_ff @(posedge clk) begin
        if (reset || io_config_load) begin
            finished_q <= 1'b0;
        end else if (wrap1) begin
            finished_q <= 1'b1;
        end
    end

    assign io_finished = finished_q;
`endif

    assign io_count0 = count0_q;
    assign io_count1 = count1_q;
    assign io_wrap0  = wrap0;
    assign io_done   = wrap1;

    // Structural invariants of the loop nest.

    // A non-zero bound is never reached by a stored count.
    a_count0_bound: assert property (@(posedge clk) disable iff (reset)
        (max0_q != '0) |-> (count0_q < max0_q));

    a_count1_bound: assert property (@(posedge clk) disable iff (reset)
        (max1_q != '0) |-> (count1_q < max1_q));

    // Done is only ever a refinement of an inner wrap.
    a_done_has_wrap0: assert property (@(posedge clk)
        io_done |-> io_wrap0);

    // Load and reset cycles never show a step.
    a_no_wrap_on_load: assert property (@(posedge clk)
        (io_config_load || reset) |-> !io_wrap0);

endmodule
